// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the sprite motion controller.
//   - motion_state_t : update sequencer states
//   - KEY_*          : USB HID usage codes for the movement keys
//   - DEF_*          : default screen / sprite / speed constants
//   - key_held()     : true when either keycode byte matches a key
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        STEP_X = 3'd2,
        STEP_Y = 3'd3,
        DONE   = 3'd4
    } motion_state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SPRITE_SIZE = 8;
    localparam int DEF_MAX_STEP    = 16;
    localparam int DEF_KEY_SPEED   = 2;

    function automatic logic key_held(input logic [15:0] keys, input logic [7:0] code);
        return (keys[15:8] == code) || (keys[7:0] == code);
    endfunction

endpackage

// File: rtl/axis_step.sv
// axis_step: one-axis motion step (combinational), shared by X and Y.
//   pos, limit       : current position and largest legal position
//   sw_vel           : signed software velocity (saturated to +/-MAX_STEP)
//   key_dec, key_inc : keyboard override toward smaller / larger position
//   invert           : negate the selected velocity (bounce direction)
//   new_pos, hit     : next position and edge-hit flag
// Optional feature: MOTION_BOUNCE_EN reflects off the edges instead of
// clamping.
module axis_step
    import motion_pkg::*;
#(
    parameter int MAX_STEP  = DEF_MAX_STEP,
    parameter int KEY_SPEED = DEF_KEY_SPEED
) (
    input  logic [9:0]         pos,
    input  logic [9:0]         limit,
    input  logic signed [31:0] sw_vel,
    input  logic               key_dec,
    input  logic               key_inc,
    input  logic               invert,
    output logic [9:0]         new_pos,
    output logic               hit
);

    localparam logic signed [31:0] SAT   = 32'(MAX_STEP);
    localparam logic signed [11:0] SAT12 = 12'(MAX_STEP);
    localparam logic signed [11:0] KEY12 = 12'(KEY_SPEED);

    logic signed [11:0] v_sel, v, lim, sum, fix;

    always_comb begin
        // Keys override software velocity; opposing keys cancel.
        if (key_dec && key_inc)  v_sel = '0;
        else if (key_dec)        v_sel = -KEY12;
        else if (key_inc)        v_sel = KEY12;
        else if (sw_vel > SAT)   v_sel = SAT12;
        else if (sw_vel < -SAT)  v_sel = -SAT12;
        else                     v_sel = sw_vel[11:0];

        v   = invert ? -v_sel : v_sel;
        lim = $signed({2'b00, limit});
        sum = $signed({2'b00, pos}) + v;
        hit = (sum < 0) || (sum > lim);

`ifdef MOTION_BOUNCE_EN
        if (sum < 0)        fix = -sum;
        else if (sum > lim) fix = lim + lim - sum;
        else                fix = sum;
`else
        fix = sum;
`endif
        // Final clamp also catches a reflection that overshoots the far edge.
        if (fix < 0)        new_pos = '0;
        else if (fix > lim) new_pos = limit;
        else                new_pos = fix[9:0];
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite position update.
//   Clk, Reset (sync, active high)
//   frame_tick, respawn_req : one-cycle request pulses
//   keycode                 : two HID codes ([15:8], [7:0])
//   x_velocity, y_velocity  : signed software velocities
//   rand_cord               : respawn X [19:10], Y [9:0]
//   pos_x, pos_y            : sprite top-left position
//   busy, update_done, hit_x, hit_y, overrun (sticky)
// A tick in IDLE runs LATCH -> STEP_X -> STEP_Y -> DONE. One axis_step
// instance is time-shared between the two STEP states.
// Optional feature: define MOTION_BOUNCE_EN for edge reflection with
// per-axis direction invert bits.
module sprite_motion_ctrl
    import motion_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    parameter int MAX_STEP    = DEF_MAX_STEP,
    parameter int KEY_SPEED   = DEF_KEY_SPEED
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               respawn_req,
    input  logic [15:0]        keycode,
    input  logic signed [31:0] x_velocity,
    input  logic signed [31:0] y_velocity,
    input  logic [19:0]        rand_cord,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y,
    output logic               busy,
    output logic               update_done,
    output logic               hit_x,
    output logic               hit_y,
    output logic               overrun
);

    localparam logic [9:0] X_LIM = 10'(SCREEN_W - SPRITE_SIZE);
    localparam logic [9:0] Y_LIM = 10'(SCREEN_H - SPRITE_SIZE);
    localparam logic [9:0] X_MID = 10'((SCREEN_W - SPRITE_SIZE) / 2);
    localparam logic [9:0] Y_MID = 10'((SCREEN_H - SPRITE_SIZE) / 2);

    motion_state_t      state;
    logic [15:0]        key_q;
    logic signed [31:0] vx_q, vy_q;

    logic               on_y;
    logic [9:0]         a_pos, a_lim, a_new;
    logic signed [31:0] a_vel;
    logic               a_dec, a_inc, a_inv, a_hit;
    logic [9:0]         spawn_x, spawn_y;

`ifdef MOTION_BOUNCE_EN
    logic inv_x, inv_y;
    assign a_inv = on_y ? inv_y : inv_x;
`else
    assign a_inv = 1'b0;
`endif

    // Shared stepper operands: Y during STEP_Y, X otherwise.
    assign on_y  = (state == STEP_Y);
    assign a_pos = on_y ? pos_y : pos_x;
    assign a_lim = on_y ? Y_LIM : X_LIM;
    assign a_vel = on_y ? vy_q  : vx_q;
    assign a_dec = on_y ? key_held(key_q, KEY_W) : key_held(key_q, KEY_A);
    assign a_inc = on_y ? key_held(key_q, KEY_S) : key_held(key_q, KEY_D);

    axis_step #(
        .MAX_STEP  (MAX_STEP),
        .KEY_SPEED (KEY_SPEED)
    ) u_step (
        .pos     (a_pos),
        .limit   (a_lim),
        .sw_vel  (a_vel),
        .key_dec (a_dec),
        .key_inc (a_inc),
        .invert  (a_inv),
        .new_pos (a_new),
        .hit     (a_hit)
    );

    assign spawn_x = (rand_cord[19:10] > X_LIM) ? X_LIM : rand_cord[19:10];
    assign spawn_y = (rand_cord[9:0]   > Y_LIM) ? Y_LIM : rand_cord[9:0];

    assign busy        = (state != IDLE);
    assign update_done = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            pos_x   <= X_MID;
            pos_y   <= Y_MID;
            hit_x   <= 1'b0;
            hit_y   <= 1'b0;
            overrun <= 1'b0;
            key_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
`ifdef MOTION_BOUNCE_EN
            inv_x   <= 1'b0;
            inv_y   <= 1'b0;
`endif
        end else begin
            if (frame_tick && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    // Respawn beats a coincident tick; the tick is lost silently.
                    if (respawn_req) begin
                        pos_x <= spawn_x;
                        pos_y <= spawn_y;
`ifdef MOTION_BOUNCE_EN
                        inv_x <= 1'b0;
                        inv_y <= 1'b0;
`endif
                    end else if (frame_tick) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    key_q <= keycode;
                    vx_q  <= x_velocity;
                    vy_q  <= y_velocity;
                    state <= STEP_X;
                end
                STEP_X: begin
                    pos_x <= a_new;
                    hit_x <= a_hit;
`ifdef MOTION_BOUNCE_EN
                    if (a_hit) inv_x <= ~inv_x;
`endif
                    state <= STEP_Y;
                end
                STEP_Y: begin
                    pos_y <= a_new;
                    hit_y <= a_hit;
`ifdef MOTION_BOUNCE_EN
                    if (a_hit) inv_y <= ~inv_y;
`endif
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: self-checking bench for sprite_motion_ctrl.
// Directed vector table, hand-written multi-cycle corner sequences, and a
// randomized run compared against an arithmetic position model.
module tb_sprite_motion_ctrl;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int SZ = 8;
    localparam int MS = 16;
    localparam int KS = 2;
    localparam int XL = W - SZ;
    localparam int YL = H - SZ;
    localparam int XC = (W - SZ) / 2;
    localparam int YC = (H - SZ) / 2;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               frame_tick = 1'b0;
    logic               respawn_req = 1'b0;
    logic [15:0]        keycode = '0;
    logic signed [31:0] x_velocity = '0;
    logic signed [31:0] y_velocity = '0;
    logic [19:0]        rand_cord = '0;
    logic [9:0]         pos_x, pos_y;
    logic               busy, update_done, hit_x, hit_y, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int mx, my;
    bit mhx, mhy, minvx, minvy, mover;

    always #5 Clk = ~Clk;

    sprite_motion_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .respawn_req (respawn_req),
        .keycode     (keycode),
        .x_velocity  (x_velocity),
        .y_velocity  (y_velocity),
        .rand_cord   (rand_cord),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .update_done (update_done),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sel_vel(input logic [15:0] k, input logic [7:0] dec,
                                   input logic [7:0] inc, input logic signed [31:0] sw);
        bit d, u;
        d = (k[15:8] == dec) || (k[7:0] == dec);
        u = (k[15:8] == inc) || (k[7:0] == inc);
        if (d && u) return 0;
        if (d) return -KS;
        if (u) return KS;
        if (sw > MS) return MS;
        if (sw < -MS) return -MS;
        return sw;
    endfunction

    task automatic model_axis(input int pos, input int vraw, input int lim,
                              output int np, output bit hit, inout bit inv);
        int s;
        s = pos + (inv ? -vraw : vraw);
        hit = (s < 0) || (s > lim);
`ifdef MOTION_BOUNCE_EN
        if (s < 0) s = -s;
        else if (s > lim) s = 2 * lim - s;
        if (hit) inv = !inv;
`endif
        np = (s < 0) ? 0 : ((s > lim) ? lim : s);
    endtask

    task automatic model_frame(input logic [15:0] k, input logic signed [31:0] xv,
                               input logic signed [31:0] yv);
        int nx, ny;
        model_axis(mx, sel_vel(k, 8'h04, 8'h07, xv), XL, nx, mhx, minvx);
        model_axis(my, sel_vel(k, 8'h1A, 8'h16, yv), YL, ny, mhy, minvy);
        mx = nx;
        my = ny;
    endtask

    task automatic model_reset();
        mx = XC; my = YC; mhx = 0; mhy = 0; minvx = 0; minvy = 0; mover = 0;
    endtask

    task automatic model_respawn(input int x, input int y);
        mx = (x > XL) ? XL : x;
        my = (y > YL) ? YL : y;
        minvx = 0;
        minvy = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " pos_x"}, 32'(pos_x), mx);
        check({tag, " pos_y"}, 32'(pos_y), my);
        check({tag, " hit_x"}, 32'(hit_x), 32'(mhx));
        check({tag, " hit_y"}, 32'(hit_y), 32'(mhy));
        check({tag, " overrun"}, 32'(overrun), 32'(mover));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        Reset = 1'b1; frame_tick = 1'b0; respawn_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    // inject: 0 none, 1 respawn during LATCH, 2 extra tick during STEP_X
    task automatic run_frame(input logic [15:0] k, input logic signed [31:0] xv,
                             input logic signed [31:0] yv, input int inject, input string tag);
        int lat;
        keycode = k; x_velocity = xv; y_velocity = yv; frame_tick = 1'b1;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            if (i == 1) begin
                frame_tick = 1'b0;
                check({tag, " busy"}, 32'(busy), 1);
                if (inject == 1) begin
                    respawn_req = 1'b1;
                    rand_cord = {10'd50, 10'd50};
                end
            end
            if (i == 2) begin
                respawn_req = 1'b0;
                if (inject == 2) frame_tick = 1'b1;
            end
            if (i == 3) frame_tick = 1'b0;
            if (update_done) begin
                lat = i;
                break;
            end
        end
        check({tag, " done latency"}, lat, 4);
        @(posedge Clk); #1;
        check({tag, " done pulse width"}, 32'(update_done), 0);
        check({tag, " busy after"}, 32'(busy), 0);
        model_frame(k, xv, yv);
        if (inject == 2) mover = 1;
    endtask

    task automatic do_respawn(input logic [19:0] rc, input bit with_tick);
        rand_cord = rc; respawn_req = 1'b1; frame_tick = with_tick;
        @(posedge Clk); #1;
        respawn_req = 1'b0; frame_tick = 1'b0;
        model_respawn(int'(rc[19:10]), int'(rc[9:0]));
    endtask

    // ---------------- directed vectors (each from reset centre) ----------------
    typedef struct {
        logic [15:0] key;
        int          xv;
        int          yv;
        int          ex;
        int          ey;
        bit          hx;
        bit          hy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int seen;
        logic [7:0] pool [6];
        logic [15:0] k;
        logic signed [31:0] xv, yv;

        vecs[0] = '{16'h0000, 5, -3, 321, 233, 0, 0};
        vecs[1] = '{16'h0407, 9, 0, 316, 236, 0, 0};
        vecs[2] = '{16'h1A00, 0, 7, 316, 234, 0, 0};
        vecs[3] = '{16'h0016, -100, 50, 300, 238, 0, 0};
        vecs[4] = '{16'h071A, 3, 3, 318, 234, 0, 0};
        vecs[5] = '{16'h1A16, 16, -9, 332, 236, 0, 0};
        vecs[6] = '{16'h0000, 32'h8000_0000, 32'h7FFF_FFFF, 300, 252, 0, 0};
        vecs[7] = '{16'h0400, 1000, 0, 314, 236, 0, 0};

        // Reset state
        do_reset();
        check("reset pos_x", 32'(pos_x), XC);
        check("reset pos_y", 32'(pos_y), YC);
        check("reset busy", 32'(busy), 0);
        check("reset update_done", 32'(update_done), 0);
        check("reset hits", {30'd0, hit_x, hit_y}, 0);
        check("reset overrun", 32'(overrun), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_frame(vecs[i].key, vecs[i].xv, vecs[i].yv, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d pos_x", i), 32'(pos_x), vecs[i].ex);
            check($sformatf("vec%0d pos_y", i), 32'(pos_y), vecs[i].ey);
            check($sformatf("vec%0d hit_x", i), 32'(hit_x), 32'(vecs[i].hx));
            check($sformatf("vec%0d hit_y", i), 32'(hit_y), 32'(vecs[i].hy));
        end

        // Right-edge hit with saturated velocity, then a small follow-up step
        do_reset();
        do_respawn({10'd630, 10'd100}, 1'b0);
        check("edge respawn pos_x", 32'(pos_x), 630);
        run_frame(16'h0000, 100, 0, 0, "edge1");
`ifdef MOTION_BOUNCE_EN
        check("edge1 pos_x", 32'(pos_x), 618);
`else
        check("edge1 pos_x", 32'(pos_x), 632);
`endif
        check("edge1 hit_x", 32'(hit_x), 1);
        check("edge1 pos_y", 32'(pos_y), 100);
        run_frame(16'h0000, 1, 0, 0, "edge2");
`ifdef MOTION_BOUNCE_EN
        check("edge2 pos_x", 32'(pos_x), 617);
        check("edge2 hit_x", 32'(hit_x), 0);
`else
        check("edge2 pos_x", 32'(pos_x), 632);
        check("edge2 hit_x", 32'(hit_x), 1);
`endif
        check_model("edge2 model");

        // Respawn and tick together: respawn wins, no update, no overrun
        do_reset();
        do_respawn({10'd700, 10'd100}, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (update_done || busy) seen++;
            @(posedge Clk); #1;
        end
        check("respawn+tick no update", seen, 0);
        check("respawn+tick pos_x", 32'(pos_x), 632);
        check("respawn+tick pos_y", 32'(pos_y), 100);
        check("respawn+tick overrun", 32'(overrun), 0);

        // Respawn while busy is dropped
        do_reset();
        run_frame(16'h0000, 2, 2, 1, "busy respawn");
        check("busy respawn pos_x", 32'(pos_x), 318);
        check("busy respawn pos_y", 32'(pos_y), 238);

        // Second tick during an update: dropped, overrun sticky until reset
        do_reset();
        run_frame(16'h0000, 3, 4, 2, "overrun");
        check_model("overrun model");
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (update_done || busy) seen++;
            @(posedge Clk); #1;
        end
        check("overrun dropped tick", seen, 0);
        run_frame(16'h0000, -1, -1, 0, "overrun later");
        check("overrun sticky", 32'(overrun), 1);
        do_reset();
        check("overrun cleared", 32'(overrun), 0);

        // Reset during STEP_X abandons the update
        do_reset();
        keycode = '0; x_velocity = 7; y_velocity = 7; frame_tick = 1'b1;
        @(posedge Clk); #1 frame_tick = 1'b0;
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        check("mid reset pos_x", 32'(pos_x), XC);
        check("mid reset pos_y", 32'(pos_y), YC);
        check("mid reset busy", 32'(busy), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (update_done || busy || pos_x != 10'(XC) || pos_y != 10'(YC)) seen++;
            @(posedge Clk); #1;
        end
        check("mid reset quiet", seen, 0);
        model_reset();

        // Randomized frames and respawns against the model
        pool[0] = 8'h00; pool[1] = 8'h04; pool[2] = 8'h07;
        pool[3] = 8'h16; pool[4] = 8'h1A; pool[5] = 8'h00;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do_respawn(20'($urandom), 1'b0);
                check_model($sformatf("rnd%0d respawn", n));
            end else begin
                pool[5] = 8'($urandom);
                k = {pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]};
                xv = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 40)) - 20);
                yv = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 40)) - 20);
                run_frame(k, xv, yv, 0, $sformatf("rnd%0d", n));
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
